// File: rtl/ecc_serial_port_if.sv
// Signal bundle between the serial host, ecc_serial_port and the ECC core.
// The slave modport is the port's own view; master is the environment's view.
interface ecc_serial_port_if #(
    parameter int MAX_BITS = 128
);
    logic                i_data_valid;
    logic                i_mode;
    logic                i_a;
    logic                i_prime;
    logic                i_Px;
    logic                i_Py;
    logic                i_m;
    logic [MAX_BITS-1:0] core_a;
    logic [MAX_BITS-1:0] core_prime;
    logic [MAX_BITS-1:0] core_Px;
    logic [MAX_BITS-1:0] core_Py;
    logic [MAX_BITS-1:0] core_m;
    logic [1:0]          core_mode;
    logic                core_start;
    logic                core_full;
    logic                core_done;
    logic [MAX_BITS-1:0] core_Rx;
    logic [MAX_BITS-1:0] core_Ry;
    logic                o_data_valid;
    logic                o_Px;
    logic                o_Py;

    modport master (
        output i_data_valid, i_mode, i_a, i_prime, i_Px, i_Py, i_m,
        output core_done, core_Rx, core_Ry,
        input  core_a, core_prime, core_Px, core_Py, core_m,
        input  core_mode, core_start, core_full,
        input  o_data_valid, o_Px, o_Py
    );

    modport slave (
        input  i_data_valid, i_mode, i_a, i_prime, i_Px, i_Py, i_m,
        input  core_done, core_Rx, core_Ry,
        output core_a, core_prime, core_Px, core_Py, core_m,
        output core_mode, core_start, core_full,
        output o_data_valid, o_Px, o_Py
    );
endinterface

// File: rtl/ecc_serial_port.sv
// Serial-to-parallel front end for an ECC core: deserialises operands,
// launches the core, and serialises the Rx/Ry result back out MSB first.
module ecc_serial_port #(
    parameter int MAX_BITS = 128
) (
    input  logic           clk,
    input  logic           rst,
    ecc_serial_port_if.slave bus
);
    localparam int CW = $clog2(MAX_BITS) + 1;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [MAX_BITS-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        MODE1,
        MODE0,
        SHIFT,
        WAIT_CORE,
        SEND
    } state_t;

    state_t     state_q, state_d;
    logic       cfg_q, cfg_d;
    cnt_t       cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    word_t      a_q, a_d;
    word_t      prime_q, prime_d;
    word_t      px_q, px_d;
    word_t      py_q, py_d;
    word_t      m_q, m_d;
    word_t      rx_q, rx_d;
    word_t      ry_q, ry_d;
    logic       start_q, start_d;
    logic       full_q, full_d;
    logic       odv_q, odv_d;
    logic       opx_q, opx_d;
    logic       opy_q, opy_d;

    cnt_t nbits;
    cnt_t align;

    assign nbits = cnt_t'(16) << mode_q;
    assign align = cnt_t'(MAX_BITS) - nbits;

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        a_d     = a_q;
        prime_d = prime_q;
        px_d    = px_q;
        py_d    = py_q;
        m_d     = m_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        start_d = 1'b0;
        full_d  = full_q;
        odv_d   = 1'b0;
        opx_d   = 1'b0;
        opy_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_data_valid) begin
                    cnt_d = '0;
                    if (cfg_q) begin
                        state_d = SHIFT;
                        full_d  = 1'b0;
                        px_d    = '0;
                        py_d    = '0;
                    end else begin
                        state_d = MODE1;
                        full_d  = 1'b1;
                    end
                end
            end
            MODE1: begin
                mode_d[1] = bus.i_mode;
                state_d   = MODE0;
            end
            MODE0: begin
                mode_d[0] = bus.i_mode;
                a_d       = '0;
                prime_d   = '0;
                px_d      = '0;
                py_d      = '0;
                m_d       = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                px_d = {px_q[MAX_BITS-2:0], bus.i_Px};
                py_d = {py_q[MAX_BITS-2:0], bus.i_Py};
                if (full_q) begin
                    a_d     = {a_q[MAX_BITS-2:0], bus.i_a};
                    prime_d = {prime_q[MAX_BITS-2:0], bus.i_prime};
                    m_d     = {m_q[MAX_BITS-2:0], bus.i_m};
                end
                cnt_d = cnt_q + cnt_t'(1);
                if (cnt_q == nbits - cnt_t'(1)) begin
                    cnt_d   = '0;
                    start_d = 1'b1;
                    state_d = WAIT_CORE;
                end
            end
            WAIT_CORE: begin
                if (bus.core_done) begin
                    // Left-justify so the active MSB always sits at the top.
                    rx_d    = bus.core_Rx << align;
                    ry_d    = bus.core_Ry << align;
                    odv_d   = 1'b1;
                    opx_d   = rx_d[MAX_BITS-1];
                    opy_d   = ry_d[MAX_BITS-1];
                    cnt_d   = cnt_t'(1);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cnt_q == nbits) begin
                    cnt_d   = '0;
                    cfg_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    opx_d = rx_q[MAX_BITS-2];
                    opy_d = ry_q[MAX_BITS-2];
                    rx_d  = rx_q << 1;
                    ry_d  = ry_q << 1;
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cfg_q   <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= '0;
            a_q     <= '0;
            prime_q <= '0;
            px_q    <= '0;
            py_q    <= '0;
            m_q     <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            start_q <= 1'b0;
            full_q  <= 1'b0;
            odv_q   <= 1'b0;
            opx_q   <= 1'b0;
            opy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            prime_q <= prime_d;
            px_q    <= px_d;
            py_q    <= py_d;
            m_q     <= m_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            start_q <= start_d;
            full_q  <= full_d;
            odv_q   <= odv_d;
            opx_q   <= opx_d;
            opy_q   <= opy_d;
        end
    end

    assign bus.core_a       = a_q;
    assign bus.core_prime   = prime_q;
    assign bus.core_Px      = px_q;
    assign bus.core_Py      = py_q;
    assign bus.core_m       = m_q;
    assign bus.core_mode    = mode_q;
    assign bus.core_start   = start_q;
    assign bus.core_full    = full_q;
    assign bus.o_data_valid = odv_q;
    assign bus.o_Px         = opx_q;
    assign bus.o_Py         = opy_q;
endmodule

// File: tb/tb_ecc_serial_port.sv
// Directed vector bench for ecc_serial_port: frame table plus abort,
// stray-strobe and stray-done sequences.
module tb_ecc_serial_port;
    localparam int MB = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ecc_serial_port_if #(.MAX_BITS(MB)) b ();

    ecc_serial_port #(.MAX_BITS(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    typedef struct {
        bit          rst_b;
        bit          full;
        logic [1:0]  mode;
        logic [127:0] a, prime, px, py, m, rx, ry;
        logic [1:0]  emode;
        bit          efull;
        logic [127:0] ea, eprime, epx, epy, em, erx, ery;
    } vec_t;

    vec_t tab[6];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " core_a"}, b.core_a, '0);
        check({tag, " core_Px"}, b.core_Px, '0);
        check({tag, " core_mode"}, {126'd0, b.core_mode}, '0);
        check({tag, " ctl"}, {b.core_start, b.core_full, b.o_data_valid,
                              b.o_Px, b.o_Py}, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_frame(input vec_t v);
        int nb;
        int starts;
        nb = 16 << v.emode;
        starts = 0;
        @(negedge clk);
        b.i_data_valid = 1'b1;
        @(negedge clk);
        b.i_data_valid = 1'b0;
        if (v.full) begin
            b.i_mode = v.mode[1];
            @(negedge clk);
            starts += int'(b.core_start);
            b.i_mode = v.mode[0];
            @(negedge clk);
        end
        b.i_mode = 1'b1;
        for (int i = 0; i < nb; i++) begin
            starts += int'(b.core_start);
            b.i_Px    = v.px[nb-1-i];
            b.i_Py    = v.py[nb-1-i];
            b.i_a     = v.full ? v.a[nb-1-i] : 1'b1;
            b.i_prime = v.full ? v.prime[nb-1-i] : 1'b1;
            b.i_m     = v.full ? v.m[nb-1-i] : 1'b1;
            @(negedge clk);
        end
        {b.i_a, b.i_prime, b.i_Px, b.i_Py, b.i_m} = '0;
        b.i_mode = 1'b0;
        check("start_early", starts, 0);
        check("core_start", b.core_start, 1'b1);
        check("core_full", b.core_full, v.efull);
        check("core_mode", {126'd0, b.core_mode}, {126'd0, v.emode});
        check("core_a", b.core_a, v.ea);
        check("core_prime", b.core_prime, v.eprime);
        check("core_Px", b.core_Px, v.epx);
        check("core_Py", b.core_Py, v.epy);
        check("core_m", b.core_m, v.em);
    endtask

    task automatic do_result(input vec_t v);
        int nb;
        int dvs;
        logic [127:0] gx, gy;
        nb = 16 << v.emode;
        b.core_done = 1'b1;
        b.core_Rx = v.rx;
        b.core_Ry = v.ry;
        @(negedge clk);
        b.core_done = 1'b0;
        b.core_Rx = '0;
        b.core_Ry = '0;
        check("start_len", b.core_start, 1'b0);
        check("o_dv_first", b.o_data_valid, 1'b1);
        dvs = 0;
        gx = '0;
        gy = '0;
        for (int i = 0; i < nb; i++) begin
            dvs += int'(b.o_data_valid);
            gx = {gx[126:0], b.o_Px};
            gy = {gy[126:0], b.o_Py};
            @(negedge clk);
        end
        check("o_dv_count", dvs, 1);
        check("o_Px_stream", gx, v.erx);
        check("o_Py_stream", gy, v.ery);
        check("o_tail_zero", {b.o_Px, b.o_Py, b.o_data_valid}, '0);
    endtask

    task automatic abort_seq();
        do_reset();
        @(negedge clk);
        b.i_data_valid = 1'b1;
        @(negedge clk);
        b.i_data_valid = 1'b0;
        b.i_mode = 1'b1;
        @(negedge clk);
        b.i_mode = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            b.i_Px = 1'b1;
            b.i_a  = 1'b1;
            @(negedge clk);
        end
        b.i_Px = 1'b0;
        b.i_a  = 1'b0;
        check("abort pre mode", {126'd0, b.core_mode}, 128'd2);
        check("abort pre Px", b.core_Px, 128'hFF_FFFF_FFFF);
        rst = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        b.i_data_valid = 1'b0;
        b.i_mode = 1'b0;
        {b.i_a, b.i_prime, b.i_Px, b.i_Py, b.i_m} = '0;
        b.core_done = 1'b0;
        b.core_Rx = '0;
        b.core_Ry = '0;

        tab[0] = '{1'b1, 1'b1, 2'b00,
            128'h3, 128'hFFF1, 128'h1234, 128'h5678, 128'hA5,
            128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_ABCD,
            128'h1234_5678_9ABC_DEF0_1111_2222_3333_0F0F,
            2'b00, 1'b1,
            128'h3, 128'hFFF1, 128'h1234, 128'h5678, 128'hA5,
            128'hABCD, 128'h0F0F};
        tab[1] = '{1'b0, 1'b0, 2'b00,
            128'h0, 128'h0, 128'h1111, 128'h2222, 128'h0,
            128'h5A5A, 128'h8001,
            2'b00, 1'b0,
            128'h3, 128'hFFF1, 128'h1111, 128'h2222, 128'hA5,
            128'h5A5A, 128'h8001};
        tab[2] = '{1'b1, 1'b1, 2'b11,
            128'h1,
            128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF61,
            {128{1'b1}},
            128'h0123456789ABCDEF_FEDCBA9876543210,
            128'h80000000_00000000_00000000_00000001,
            {128{1'b1}},
            128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
            2'b11, 1'b1,
            128'h1,
            128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF61,
            {128{1'b1}},
            128'h0123456789ABCDEF_FEDCBA9876543210,
            128'h80000000_00000000_00000000_00000001,
            {128{1'b1}},
            128'h0123_4567_89AB_CDEF_0011_2233_4455_6677};
        tab[3] = '{1'b0, 1'b0, 2'b11,
            128'h0, 128'h0,
            128'hDEADBEEF_00000000_CAFEBABE_12345678, 128'h1, 128'h0,
            128'h80000000_00000000_00000000_00000000, 128'h1,
            2'b11, 1'b0,
            128'h1,
            128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF61,
            128'hDEADBEEF_00000000_CAFEBABE_12345678, 128'h1,
            128'h80000000_00000000_00000000_00000001,
            128'h80000000_00000000_00000000_00000000, 128'h1};
        tab[4] = '{1'b0, 1'b1, 2'b01,
            128'hDEADBEEF, 128'hFFFFFFFB, 128'h80000001,
            128'h7FFFFFFE, 128'h13579BDF,
            128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_600DF00D, 128'h0,
            2'b01, 1'b1,
            128'hDEADBEEF, 128'hFFFFFFFB, 128'h80000001,
            128'h7FFFFFFE, 128'h13579BDF,
            128'h600DF00D, 128'h0};
        tab[5] = '{1'b0, 1'b0, 2'b01,
            128'h0, 128'h0, 128'h0000FFFF, 128'hFFFF0000, 128'h0,
            128'h12345678, 128'h9ABCDEF0,
            2'b01, 1'b0,
            128'hDEADBEEF, 128'hFFFFFFFB, 128'h0000FFFF,
            128'hFFFF0000, 128'h13579BDF,
            128'h12345678, 128'h9ABCDEF0};

        #1;
        check_zero("reset");

        for (int i = 0; i < 6; i++) begin
            if (i == 4) abort_seq();
            if (tab[i].rst_b) do_reset();
            do_frame(tab[i]);
            do_result(tab[i]);
        end

        begin : stray_events
            int hits;
            do_reset();
            do_frame(tab[0]);
            hits = 0;
            b.i_data_valid = 1'b1;
            repeat (3) begin
                @(negedge clk);
                hits += int'(b.core_start) + int'(b.o_data_valid);
            end
            b.i_data_valid = 1'b0;
            check("valid_in_wait", hits, 0);
            do_result(tab[0]);
            b.core_done = 1'b1;
            b.core_Rx = {128{1'b1}};
            b.core_Ry = {128{1'b1}};
            hits = 0;
            @(negedge clk);
            b.core_done = 1'b0;
            b.core_Rx = '0;
            b.core_Ry = '0;
            repeat (4) begin
                hits += int'(b.core_start) + int'(b.o_data_valid)
                      + int'(b.o_Px) + int'(b.o_Py);
                @(negedge clk);
            end
            check("done_in_idle", hits, 0);
            do_frame(tab[1]);
            do_result(tab[1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
